// File: rtl/tohost_ctrl_if.sv
// Core/console-facing signal bundle for tohost_ctrl.
// master = core plus console sink (testbench side); slave = the controller.
interface tohost_ctrl_if;
    logic        tohost_we;
    logic [31:0] tohost;
    logic        stall;
    logic        fromhost_we;
    logic [31:0] fromhost;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;
    logic        overflow;
    logic        timeout;

    modport master (
        output tohost_we, tohost, con_ready,
        input  stall, fromhost_we, fromhost, con_valid, con_data,
        input  done, pass, exit_code, overflow, timeout
    );

    modport slave (
        input  tohost_we, tohost, con_ready,
        output stall, fromhost_we, fromhost, con_valid, con_data,
        output done, pass, exit_code, overflow, timeout
    );
endinterface

// File: rtl/tohost_ctrl.sv
// Decodes core tohost writes into console putchar (buffered), exit and bad-command events.
// The idle watchdog is only built when TOHOST_CTRL_WDT_EN is defined.
module tohost_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WDT_CYCLES = 1000000
) (
    input logic          CLK,
    input logic          RSTn,
    tohost_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          overflow_q, overflow_d;
    logic          pass_q, pass_d;
    logic [30:0]   exit_code_q, exit_code_d;
    logic          push, pop, wdt_fire;
    logic          is_exit, is_putc;

    assign is_exit = bus.tohost[0];
    assign is_putc = (bus.tohost[31:24] == 8'h01) && !bus.tohost[0];
    assign pop     = (count_q != '0) && bus.con_ready;

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        overflow_d  = overflow_q;
        pass_d      = pass_q;
        exit_code_d = exit_code_q;
        case (state_q)
            RUN, ACK: begin
                if (wdt_fire) begin
                    state_d     = DRAIN;
                    pass_d      = 1'b0;
                    exit_code_d = '1;
                end else if (state_q == ACK) begin
                    state_d = RUN;
                    if (bus.tohost_we) overflow_d = 1'b1;
                end else if (bus.tohost_we && (bus.tohost != '0)) begin
                    if (is_exit) begin
                        exit_code_d = bus.tohost[31:1];
                        pass_d      = (bus.tohost[31:1] == '0);
                        state_d     = DRAIN;
                    end else if (is_putc) begin
                        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
                        if (!full_q || pop) begin
                            push    = 1'b1;
                            state_d = ACK;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        exit_code_d = '1;
                        pass_d      = 1'b0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_q == '0) state_d = HALT;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            pass_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            full_q      <= (count_d == FULL_CNT);
            overflow_q  <= overflow_d;
            pass_q      <= pass_d;
            exit_code_q <= exit_code_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.tohost[7:0];
    end

`ifdef TOHOST_CTRL_WDT_EN
    logic [31:0] wdt_q;
    logic        timeout_q;
    logic        wdt_active;

    assign wdt_active = (state_q == RUN) || (state_q == ACK);
    assign wdt_fire   = wdt_active && !bus.tohost_we && (wdt_q == 32'(WDT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!wdt_active || bus.tohost_we || wdt_fire) begin
                wdt_q <= '0;
            end else begin
                wdt_q <= wdt_q + 32'd1;
            end
            if (wdt_fire) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign wdt_fire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.stall       = full_q;
    assign bus.fromhost_we = (state_q == ACK);
    assign bus.fromhost    = {31'b0, state_q == ACK};
    assign bus.con_valid   = (count_q != '0);
    // Gated so the output is zero in reset even though the storage itself is not reset.
    assign bus.con_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.done        = (state_q == HALT);
    assign bus.pass        = pass_q;
    assign bus.exit_code   = exit_code_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_tohost_ctrl.sv
// Testbench for tohost_ctrl: vector table, directed corner sequences, and random traffic
// checked against a queue-based model. Watchdog checks follow TOHOST_CTRL_WDT_EN.
module tb_tohost_ctrl;
    localparam int DEPTH = 4;
    localparam int WDT   = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    tohost_ctrl_if bus ();

    tohost_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .WDT_CYCLES(WDT)
    ) dut (
        .CLK (clk),
        .RSTn(rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        bit          we;
        logic [31:0] data;
        bit          rdy;
        bit          fw;
        bit          cv;
        logic [7:0]  cd;
        bit          stall;
        bit          ovf;
    } vec_t;

    // Behavioural model state.
    byte unsigned m_q[$];
    bit           m_ack, m_drain, m_halt, m_ovf, m_pass, m_tmo;
    logic [30:0]  m_code;
    int           m_idle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 64'(bus.stall), 0);
        chk({tag, "_fromhost_we"}, 64'(bus.fromhost_we), 0);
        chk({tag, "_fromhost"}, 64'(bus.fromhost), 0);
        chk({tag, "_con_valid"}, 64'(bus.con_valid), 0);
        chk({tag, "_con_data"}, 64'(bus.con_data), 0);
        chk({tag, "_done"}, 64'(bus.done), 0);
        chk({tag, "_pass"}, 64'(bus.pass), 0);
        chk({tag, "_exit_code"}, 64'(bus.exit_code), 0);
        chk({tag, "_overflow"}, 64'(bus.overflow), 0);
        chk({tag, "_timeout"}, 64'(bus.timeout), 0);
    endtask

    task automatic do_reset(input string tag);
        bus.tohost_we = 1'b0;
        bus.tohost    = '0;
        bus.con_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_zero(tag);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] d);
        bus.tohost_we = 1'b1;
        bus.tohost    = d;
        tick();
        bus.tohost_we = 1'b0;
        bus.tohost    = '0;
    endtask

    task automatic wait_done(input int lim, input string name);
        int n = 0;
        while (!bus.done && n < lim) begin
            tick();
            n++;
        end
        chk(name, 64'(bus.done), 1);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ack = 0; m_drain = 0; m_halt = 0; m_ovf = 0; m_pass = 0; m_tmo = 0;
        m_code = '0;
        m_idle = 0;
    endtask

    // One clock edge of the model, given the inputs present before the edge.
    task automatic model_edge(input bit we, input logic [31:0] d, input bit rdy);
        int  sz;
        bit  popped, fire, was_ack, active, do_push;
        byte unsigned pv;
        sz      = m_q.size();
        popped  = (sz != 0) && rdy;
        was_ack = m_ack;
        m_ack   = 0;
        active  = !m_drain && !m_halt;
        fire    = 0;
        do_push = 0;
        pv      = 0;
`ifdef TOHOST_CTRL_WDT_EN
        if (active) begin
            if (we) m_idle = 0;
            else if (m_idle == WDT - 1) begin
                fire = 1;
                m_idle = 0;
            end else m_idle++;
        end else m_idle = 0;
`endif
        if (m_halt) begin
        end else if (m_drain) begin
            if (sz == 0) m_halt = 1;
        end else if (fire) begin
            m_tmo = 1; m_pass = 0; m_code = '1; m_drain = 1;
        end else if (was_ack) begin
            if (we) m_ovf = 1;
        end else if (we && d != 0) begin
            if (d[0]) begin
                m_code = d[31:1]; m_pass = (d[31:1] == 0); m_drain = 1;
            end else if (d[31:24] == 8'h01) begin
                if (sz < DEPTH || popped) begin
                    do_push = 1; pv = d[7:0]; m_ack = 1;
                end else m_ovf = 1;
            end else begin
                m_code = '1; m_pass = 0; m_drain = 1;
            end
        end
        if (popped) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pv);
    endtask

    task automatic model_cmp();
        chk("rand_stall", 64'(bus.stall), 64'(m_q.size() == DEPTH));
        chk("rand_fromhost_we", 64'(bus.fromhost_we), 64'(m_ack));
        chk("rand_fromhost", 64'(bus.fromhost), 64'(m_ack));
        chk("rand_con_valid", 64'(bus.con_valid), 64'(m_q.size() != 0));
        chk("rand_con_data", 64'(bus.con_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'h0);
        chk("rand_done", 64'(bus.done), 64'(m_halt));
        chk("rand_pass", 64'(bus.pass), 64'(m_pass));
        chk("rand_exit_code", 64'(bus.exit_code), 64'(m_code));
        chk("rand_overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("rand_timeout", 64'(bus.timeout), 64'(m_tmo));
    endtask

    initial begin
        vec_t         vt[15];
        byte unsigned got[$];
        int           n;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.tohost_we = 1'b0;
        bus.tohost    = '0;
        bus.con_ready = 1'b0;

        // Single putchar with transfer, then fill to full, drop the fifth, drain in order.
        vt[0]  = '{1'b1, 32'h0100_0042, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 32'h0100_0032, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 32'h0100_0034, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 32'h0100_0036, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 32'h0100_0038, 1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h32, 1'b1, 1'b0};
        vt[10] = '{1'b1, 32'h0100_003A, 1'b0, 1'b0, 1'b1, 8'h32, 1'b1, 1'b1};
        vt[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1};
        vt[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 8'h36, 1'b0, 1'b1};
        vt[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 8'h38, 1'b0, 1'b1};
        vt[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        do_reset("reset0");
        for (int i = 0; i < 15; i++) begin
            bus.tohost_we = vt[i].we;
            bus.tohost    = vt[i].data;
            bus.con_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_fromhost_we", i), 64'(bus.fromhost_we), 64'(vt[i].fw));
            chk($sformatf("vec%0d_fromhost", i), 64'(bus.fromhost), 64'(vt[i].fw));
            chk($sformatf("vec%0d_con_valid", i), 64'(bus.con_valid), 64'(vt[i].cv));
            chk($sformatf("vec%0d_con_data", i), 64'(bus.con_data), 64'(vt[i].cd));
            chk($sformatf("vec%0d_stall", i), 64'(bus.stall), 64'(vt[i].stall));
            chk($sformatf("vec%0d_overflow", i), 64'(bus.overflow), 64'(vt[i].ovf));
            chk($sformatf("vec%0d_done", i), 64'(bus.done), 0);
        end
        bus.tohost_we = 1'b0;
        bus.tohost    = '0;

        // Low bit set makes this word an exit, not a putchar.
        do_reset("reset1");
        bus.con_ready = 1'b1;
        wr(32'h0100_0041);
        chk("odd_word_con_valid", 64'(bus.con_valid), 0);
        chk("odd_word_fromhost_we", 64'(bus.fromhost_we), 0);
        chk("odd_word_exit_code", 64'(bus.exit_code), 64'h0080_0020);
        chk("odd_word_pass", 64'(bus.pass), 0);
        wait_done(4, "odd_word_done");

        // Clean exit: done, pass, code 0; later writes ignored.
        do_reset("reset2");
        wr(32'h1);
        chk("exit_ok_done_early", 64'(bus.done), 0);
        wait_done(4, "exit_ok_done");
        chk("exit_ok_pass", 64'(bus.pass), 1);
        chk("exit_ok_code", 64'(bus.exit_code), 0);
        wr(32'h0100_0044);
        tick();
        chk("halt_ignores_putc", 64'(bus.con_valid), 0);
        chk("halt_sticky_done", 64'(bus.done), 1);

        // Exit code 5 with three characters pending behind a blocked sink.
        do_reset("reset3");
        wr(32'h0100_0042); tick();
        wr(32'h0100_0044); tick();
        wr(32'h0100_0046); tick();
        wr(32'h0000_000B);
        repeat (10) tick();
        chk("drain_blocked_done", 64'(bus.done), 0);
        chk("drain_blocked_con_data", 64'(bus.con_data), 8'h42);
        bus.con_ready = 1'b1;
        n = 0;
        while (got.size() < 3 && n < 20) begin
            if (bus.con_valid) got.push_back(bus.con_data);
            tick();
            n++;
        end
        chk("drain_count", 64'(got.size()), 3);
        if (got.size() == 3) begin
            chk("drain_char0", 64'(got[0]), 8'h42);
            chk("drain_char1", 64'(got[1]), 8'h44);
            chk("drain_char2", 64'(got[2]), 8'h46);
        end
        wait_done(4, "drain_done");
        chk("drain_pass", 64'(bus.pass), 0);
        chk("drain_exit_code", 64'(bus.exit_code), 5);

        // Watchdog behaviour from reset with no writes.
        do_reset("reset4");
`ifdef TOHOST_CTRL_WDT_EN
        repeat (WDT - 1) tick();
        chk("wdt_before", 64'(bus.timeout), 0);
        tick();
        chk("wdt_timeout", 64'(bus.timeout), 1);
        chk("wdt_exit_code", 64'(bus.exit_code), 64'h7FFF_FFFF);
        chk("wdt_pass", 64'(bus.pass), 0);
        wait_done(3, "wdt_done");
`else
        repeat (100) tick();
        chk("nowdt_done", 64'(bus.done), 0);
        chk("nowdt_timeout", 64'(bus.timeout), 0);
`endif

        // Reset while draining with two characters buffered.
        do_reset("reset5");
        wr(32'h0100_0048); tick();
        wr(32'h0100_004A); tick();
        wr(32'h1);
        chk("pre_rst_con_valid", 64'(bus.con_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_drain_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_con_valid", 64'(bus.con_valid), 0);
        wr(32'h1);
        wait_done(4, "post_rst_done");
        chk("post_rst_pass", 64'(bus.pass), 1);

        // Random traffic against the model.
        do_reset("reset6");
        model_reset();
        for (int c = 0; c < 900; c++) begin
            bit          we, rdy;
            logic [31:0] d;
            int          r;
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset("rand_rst");
                model_reset();
                continue;
            end
            we = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 99);
            if (r < 80) begin
                d = {8'h01, 16'($urandom), 8'($urandom)};
                d[0] = 1'b0;
            end else if (r < 92) begin
                d = '0;
            end else if (r < 96) begin
                d = $urandom | 32'h1;
                if ($urandom_range(0, 1) == 0) d = 32'h1;
            end else begin
                d = {8'($urandom_range(2, 255)), 24'($urandom)};
                d[0] = 1'b0;
            end
            rdy = ($urandom_range(0, 1) == 1);
            bus.tohost_we = we;
            bus.tohost    = d;
            bus.con_ready = rdy;
            model_edge(we, d, rdy);
            tick();
            model_cmp();
        end
        bus.tohost_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
